mem_stage_lsu: RTL and testbench

//  EX->MEM pipeline register plus load/store unit driving the word-wide data memory (async read, sync word write, no byte enables).

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/mem_stage_lsu_if.sv | 50 +++++
 rtl/lsu_load_align.sv | 43 ++++
 rtl/mem_stage_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// =============================================================================
// Package : lsu_pkg
// Brief   : Shared funct3 encodings, FSM states and stage-register type.
// Rev     : 1.0
// =============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    RMW = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       reg_write;
  } m_ctrl_t;

  // Misalignment, illegal funct3, or a conflicting read+write request.
  function automatic logic access_err(input logic       is_ld,
                                      input logic       is_st,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    e = 1'b0;
    if (is_ld && is_st) begin
      e = 1'b1;
    end else if (is_ld) begin
      case (f3)
        F3_LB, F3_LBU: e = 1'b0;
        F3_LH, F3_LHU: e = a[0];
        F3_LW:         e = (a != 2'b00);
        default:       e = 1'b1;
      endcase
    end else if (is_st) begin
      case (f3)
        F3_SB:   e = 1'b0;
        F3_SH:   e = a[0];
        F3_SW:   e = (a != 2'b00);
        default: e = 1'b1;
      endcase
    end
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
// =============================================================================
// Interface : mem_stage_lsu_if
// Brief     : EX handshake, data-memory port and MEM/WB outputs of the LSU.
// Rev       : 1.0
// =============================================================================
`default_nettype none

interface mem_stage_lsu_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int XLEN       = 32
);

  logic                  ex_valid;
  logic                  ex_ready;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [2:0]            ex_funct3;
  logic [XLEN-1:0]       ex_result;
  logic [XLEN-1:0]       ex_store_data;
  logic [4:0]            ex_rd;
  logic                  ex_reg_write;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write_en;
  logic [XLEN-1:0]       mem_write_data;
  logic [XLEN-1:0]       mem_read_data;

  logic                  wb_valid;
  logic                  wb_reg_write;
  logic [4:0]            wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_access_err;

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_result,
           ex_store_data, ex_rd, ex_reg_write, mem_read_data,
    input  ex_ready, mem_addr, mem_write_en, mem_write_data,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_access_err
  );

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_result,
           ex_store_data, ex_rd, ex_reg_write, mem_read_data,
    output ex_ready, mem_addr, mem_write_en, mem_write_data,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_access_err
  );

endinterface

`default_nettype wire

// File: rtl/lsu_load_align.sv
// =============================================================================
// Module : lsu_load_align
// Brief  : Extracts and sign/zero-extends a byte or half from a memory word.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = addr_lo[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, w_half};
      default: data = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// =============================================================================
// Module : mem_stage_lsu
// Brief  : EX->MEM stage register and load/store unit with RMW sub-word stores.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int XLEN       = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_stage_lsu_if.slave bus
);

  lsu_state_t      state_q, state_d;
  m_ctrl_t         m_q, m_d;
  logic [XLEN-1:0] m_result_q, m_result_d;
  logic [XLEN-1:0] m_store_data_q, m_store_data_d;
  logic [XLEN-1:0] merge_q, merge_d;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_err_q, wb_err_d;

  logic            w_err;
  logic            w_sub_store;
  logic            w_word_store;
  logic            w_ready;
  logic            w_retire;
  logic            w_wen;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_merged;

  assign w_err        = access_err(m_q.mem_read, m_q.mem_write, m_q.funct3, m_result_q[1:0]);
  assign w_sub_store  = m_q.valid && m_q.mem_write && !m_q.mem_read && !w_err &&
                        ((m_q.funct3 == F3_SB) || (m_q.funct3 == F3_SH));
  assign w_word_store = m_q.valid && m_q.mem_write && !m_q.mem_read && !w_err &&
                        (m_q.funct3 == F3_SW);

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3  (m_q.funct3),
    .addr_lo (m_result_q[1:0]),
    .word    (bus.mem_read_data),
    .data    (w_load_data)
  );

  // Insert the store lane into the word captured during the RUN cycle.
  always_comb begin
    w_merged = merge_q;
    if (m_q.funct3 == F3_SH) begin
      if (m_result_q[1]) w_merged[31:16] = m_store_data_q[15:0];
      else               w_merged[15:0]  = m_store_data_q[15:0];
    end else begin
      case (m_result_q[1:0])
        2'd0:    w_merged[7:0]   = m_store_data_q[7:0];
        2'd1:    w_merged[15:8]  = m_store_data_q[7:0];
        2'd2:    w_merged[23:16] = m_store_data_q[7:0];
        default: w_merged[31:24] = m_store_data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    m_d            = m_q;
    m_result_d     = m_result_q;
    m_store_data_d = m_store_data_q;
    merge_d        = merge_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_err_d       = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    w_ready        = 1'b1;
    w_retire       = 1'b0;
    w_wen          = 1'b0;
    w_wdata        = m_store_data_q;

    case (state_q)
      RUN: begin
        if (m_q.valid) begin
          if (w_sub_store) begin
            w_ready = 1'b0;
            merge_d = bus.mem_read_data;
            state_d = RMW;
          end else begin
            w_retire       = 1'b1;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = m_q.reg_write && !w_err;
            wb_rd_d        = m_q.rd;
            wb_err_d       = w_err;
            wb_data_d      = (m_q.mem_read && !w_err) ? w_load_data : m_result_q;
            w_wen          = w_word_store;
          end
        end
      end
      RMW: begin
        w_wen          = 1'b1;
        w_wdata        = w_merged;
        w_retire       = 1'b1;
        wb_valid_d     = 1'b1;
        wb_reg_write_d = m_q.reg_write;
        wb_rd_d        = m_q.rd;
        wb_data_d      = m_result_q;
        state_d        = RUN;
      end
      default: state_d = RUN;
    endcase

    if (bus.ex_valid && w_ready) begin
      m_d.valid      = 1'b1;
      m_d.mem_read   = bus.ex_mem_read;
      m_d.mem_write  = bus.ex_mem_write;
      m_d.funct3     = bus.ex_funct3;
      m_d.rd         = bus.ex_rd;
      m_d.reg_write  = bus.ex_reg_write;
      m_result_d     = bus.ex_result;
      m_store_data_d = bus.ex_store_data;
    end else if (w_retire) begin
      m_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      m_q            <= '0;
      m_result_q     <= '0;
      m_store_data_q <= '0;
      merge_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      m_result_q     <= m_result_d;
      m_store_data_q <= m_store_data_d;
      merge_q        <= merge_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_err_q       <= wb_err_d;
    end
  end

  assign bus.ex_ready       = w_ready;
  assign bus.mem_addr       = m_result_q[ADDR_WIDTH+1:2];
  assign bus.mem_write_en   = w_wen;
  assign bus.mem_write_data = w_wdata;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_reg_write   = wb_reg_write_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.wb_access_err  = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// =============================================================================
// Module : tb_mem_stage_lsu
// Brief  : Directed self-checking bench for mem_stage_lsu with a word memory.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_WIDTH(8), .XLEN(32)) bus ();

  mem_stage_lsu #(.ADDR_WIDTH(8), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = 8'd0;
  logic [31:0] bd_data = 32'd0;

  assign bus.mem_read_data = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_data;
    else if (bd_we)       mem[bd_addr]      <= bd_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    bus.ex_valid      = 1'b1;
    bus.ex_mem_read   = ld;
    bus.ex_mem_write  = st;
    bus.ex_funct3     = f3;
    bus.ex_result     = addr;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    bus.ex_reg_write  = rw;
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_mem_write = 1'b0;
    bus.ex_reg_write = 1'b0;
  endtask

  task automatic backdoor(input logic [7:0] a, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    step();
    bd_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.ex_funct3     = 3'd0;
    bus.ex_result     = 32'd0;
    bus.ex_store_data = 32'd0;
    bus.ex_rd         = 5'd0;

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wen", bus.mem_write_en, 0);
    chk("rst_wb_err", bus.wb_access_err, 0);
    chk("rst_wb_rw", bus.wb_reg_write, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", bus.ex_ready, 1);

    backdoor(8'd0, 32'hCAFE_F00D);
    backdoor(8'd1, 32'h8070_F0FF);
    backdoor(8'd3, 32'h5566_7788);

    // Back-to-back loads from word 1
    drive(1, 0, F3_LB, 32'h7, 32'h0, 5'd5, 1);
    step();
    chk("lb_ready", bus.ex_ready, 1);
    drive(1, 0, F3_LBU, 32'h7, 32'h0, 5'd6, 1);
    step();
    chk("lb_valid", bus.wb_valid, 1);
    chk("lb_data", bus.wb_data, 32'hFFFF_FF80);
    chk("lb_rd", bus.wb_rd, 5);
    chk("lb_rw", bus.wb_reg_write, 1);
    drive(1, 0, F3_LH, 32'h6, 32'h0, 5'd7, 1);
    step();
    chk("lbu_valid", bus.wb_valid, 1);
    chk("lbu_data", bus.wb_data, 32'h0000_0080);
    chk("lbu_rd", bus.wb_rd, 6);
    drive(1, 0, F3_LW, 32'h4, 32'h0, 5'd8, 1);
    step();
    chk("lh_data", bus.wb_data, 32'hFFFF_8070);
    chk("lh_err", bus.wb_access_err, 0);
    idle();
    step();
    chk("lw_valid", bus.wb_valid, 1);
    chk("lw_data", bus.wb_data, 32'h8070_F0FF);
    chk("lw_rd", bus.wb_rd, 8);
    step();
    chk("hold_valid", bus.wb_valid, 0);
    chk("hold_rw", bus.wb_reg_write, 0);
    chk("hold_data", bus.wb_data, 32'h8070_F0FF);
    chk("hold_rd", bus.wb_rd, 8);

    // SB through read-modify-write
    backdoor(8'd1, 32'h1122_3344);
    drive(0, 1, F3_SB, 32'h5, 32'h1234_56AB, 5'd0, 0);
    step();
    chk("sb_stall", bus.ex_ready, 0);
    chk("sb_no_wen", bus.mem_write_en, 0);
    idle();
    step();
    chk("sb_n1_valid", bus.wb_valid, 0);
    chk("sb_rmw_ready", bus.ex_ready, 1);
    chk("sb_rmw_wen", bus.mem_write_en, 1);
    chk("sb_rmw_wdata", bus.mem_write_data, 32'h1122_AB44);
    step();
    chk("sb_n2_valid", bus.wb_valid, 1);
    chk("sb_err", bus.wb_access_err, 0);
    chk("sb_mem", mem[1], 32'h1122_AB44);

    // SW then LW to the same word, then a wrapped address
    drive(0, 1, F3_SW, 32'h8, 32'hDEAD_BEEF, 5'd0, 0);
    step();
    chk("sw_wen", bus.mem_write_en, 1);
    chk("sw_wdata", bus.mem_write_data, 32'hDEAD_BEEF);
    chk("sw_ready", bus.ex_ready, 1);
    drive(1, 0, F3_LW, 32'h8, 32'h0, 5'd10, 1);
    step();
    chk("sw_valid", bus.wb_valid, 1);
    chk("sw_rw", bus.wb_reg_write, 0);
    chk("raw_ready", bus.ex_ready, 1);
    drive(1, 0, F3_LW, 32'h404, 32'h0, 5'd11, 1);
    step();
    chk("raw_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("raw_rd", bus.wb_rd, 10);
    idle();
    step();
    chk("wrap_data", bus.wb_data, 32'h1122_AB44);

    // Access errors
    drive(1, 0, F3_LW, 32'h2, 32'h0, 5'd9, 1);
    step();
    drive(0, 1, F3_SH, 32'h3, 32'h0000_FFFF, 5'd0, 0);
    step();
    chk("lw_mis_valid", bus.wb_valid, 1);
    chk("lw_mis_err", bus.wb_access_err, 1);
    chk("lw_mis_rw", bus.wb_reg_write, 0);
    chk("sh_mis_ready", bus.ex_ready, 1);
    chk("sh_mis_wen", bus.mem_write_en, 0);
    drive(1, 1, F3_LW, 32'h0, 32'h0, 5'd12, 1);
    step();
    chk("sh_mis_valid", bus.wb_valid, 1);
    chk("sh_mis_err", bus.wb_access_err, 1);
    drive(1, 0, 3'b011, 32'h0, 32'h0, 5'd13, 1);
    step();
    chk("rdwr_err", bus.wb_access_err, 1);
    chk("rdwr_rw", bus.wb_reg_write, 0);
    idle();
    step();
    chk("f3_err", bus.wb_access_err, 1);
    chk("f3_rw", bus.wb_reg_write, 0);
    step();
    chk("err_clear", bus.wb_access_err, 0);
    chk("err_clear_valid", bus.wb_valid, 0);
    chk("err_mem", mem[0], 32'hCAFE_F00D);

    // Reset pulsed during the RMW cycle of an SH
    drive(0, 1, F3_SH, 32'hE, 32'h0000_1234, 5'd0, 0);
    step();
    chk("sh_stall", bus.ex_ready, 0);
    idle();
    step();
    chk("sh_rmw_wen", bus.mem_write_en, 1);
    chk("sh_rmw_wdata", bus.mem_write_data, 32'h1234_7788);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_wen", bus.mem_write_en, 0);
    chk("rstmid_valid", bus.wb_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rstmid_mem", mem[3], 32'h5566_7788);
    chk("rstmid_valid2", bus.wb_valid, 0);
    chk("rstmid_ready", bus.ex_ready, 1);
    drive(1, 0, F3_LW, 32'hC, 32'h0, 5'd14, 1);
    step();
    chk("post_rst_ready", bus.ex_ready, 1);
    idle();
    step();
    chk("post_rst_valid", bus.wb_valid, 1);
    chk("post_rst_data", bus.wb_data, 32'h5566_7788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
